// File: rtl/result_log_pkg.sv
// Shared types and widths for the result history and BCD display slice.
package result_log_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cvt_state_e;

    localparam int BCD_W     = 12;
    localparam int DATA_W    = 8;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/result_log_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one bit per cycle.
module bin2bcd_seq
    import result_log_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Bin,
    output logic [BCD_W-1:0]  Bcd,
    output logic              Done
);

    localparam int SW = BCD_W + DATA_W;

    cvt_state_e       r_state;
    logic [2:0]       r_cnt;
    logic [SW-1:0]    r_sh;
    logic [BCD_W-1:0] r_bcd;
    logic             r_done;
    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_shf;

    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_sh[DATA_W + 4 * i +: 4] >= 4'd5)
                w_adj[DATA_W + 4 * i +: 4] = r_sh[DATA_W + 4 * i +: 4] + 4'd3;
        end
        w_shf = {w_adj[SW-2:0], 1'b0};
    end

    // Start wins over an in-flight shift so a new value restarts cleanly.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b1;
        end else if (Start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_sh    <= {{BCD_W{1'b0}}, Bin};
            r_done  <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_sh  <= w_shf;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_bcd   <= w_shf[SW-1:DATA_W];
                r_done  <= 1'b1;
                r_state <= IDLE;
            end
        end
    end

    assign Bcd  = r_bcd;
    assign Done = r_done;

endmodule

// File: rtl/result_log.sv
// Circular history of evaluator results with browse key and BCD display.
module result_log
    import result_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        DataResult,
    input  logic                     ResultValid,
    input  logic                     Next,
    input  logic                     Clear,
    output logic [DATA_W-1:0]        DispValue,
    output logic [$clog2(DEPTH)-1:0] DispIndex,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [BCD_W-1:0]         Bcd,
    output logic                     BcdValid,
    output logic                     NewResult
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_off;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_disp;
    logic              r_valid_d;
    logic              r_next_d;
    logic              r_new;

    logic              w_cap;
    logic              w_browse;
    logic              w_start;
    logic [AW-1:0]     w_off_nxt;
    logic [AW-1:0]     w_rd_idx;
    logic [DATA_W-1:0] w_disp_nxt;

    // Clear > capture > browse; the three qualifiers are mutually exclusive.
    assign w_cap    = ResultValid & ~r_valid_d & ~Clear;
    assign w_browse = Next & ~r_next_d & (r_count != '0) & ~w_cap & ~Clear;
    assign w_start  = Clear | w_cap | w_browse;

    assign w_off_nxt = ({1'b0, r_off} == r_count - CW'(1)) ? '0 : r_off + AW'(1);
    assign w_rd_idx  = r_wr_ptr - AW'(1) - w_off_nxt;

    always_comb begin
        w_disp_nxt = r_disp;
        unique case (1'b1)
            Clear:    w_disp_nxt = '0;
            w_cap:    w_disp_nxt = DataResult;
            w_browse: w_disp_nxt = r_buf[w_rd_idx];
            default:  w_disp_nxt = r_disp;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (w_cap)
            r_buf[r_wr_ptr] <= DataResult;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr  <= '0;
            r_off     <= '0;
            r_count   <= '0;
            r_disp    <= '0;
            r_valid_d <= 1'b0;
            r_next_d  <= 1'b0;
            r_new     <= 1'b0;
        end else begin
            r_valid_d <= ResultValid;
            r_next_d  <= Next;
            r_new     <= w_cap;
            r_disp    <= w_disp_nxt;
            if (Clear) begin
                r_wr_ptr <= '0;
                r_off    <= '0;
                r_count  <= '0;
            end else if (w_cap) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_off    <= '0;
                if (r_count != FULL)
                    r_count <= r_count + CW'(1);
            end else if (w_browse) begin
                r_off <= w_off_nxt;
            end
        end
    end

    bin2bcd_seq u_bcd (
        .Clock (Clock),
        .Reset (Reset),
        .Start (w_start),
        .Bin   (w_disp_nxt),
        .Bcd   (Bcd),
        .Done  (BcdValid)
    );

    assign DispValue = r_disp;
    assign DispIndex = r_off;
    assign Count     = r_count;
    assign NewResult = r_new;

endmodule

// File: tb/tb_result_log.sv
// Bench for result_log: history-queue model compared every cycle plus directed literals.
module tb_result_log;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  DataResult = '0;
    logic        ResultValid = 1'b0;
    logic        Next = 1'b0;
    logic        Clear = 1'b0;
    logic [7:0]  DispValue;
    logic [1:0]  DispIndex;
    logic [2:0]  Count;
    logic [11:0] Bcd;
    logic        BcdValid;
    logic        NewResult;

    int checks = 0;
    int errors = 0;

    result_log #(.DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataResult  (DataResult),
        .ResultValid (ResultValid),
        .Next        (Next),
        .Clear       (Clear),
        .DispValue   (DispValue),
        .DispIndex   (DispIndex),
        .Count       (Count),
        .Bcd         (Bcd),
        .BcdValid    (BcdValid),
        .NewResult   (NewResult)
    );

    always #5 Clock = ~Clock;

    // Model: newest-first queue, browse offset, BCD countdown.
    int hist[$];
    int m_off;
    bit m_prv;
    bit m_pnx;
    bit m_new;
    bit m_ok;
    int m_bcd;
    int m_pend;
    int m_timer;

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int m_disp();
        return (hist.size() > 0) ? hist[m_off] : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_off   = 0;
        m_prv   = 0;
        m_pnx   = 0;
        m_new   = 0;
        m_ok    = 1;
        m_bcd   = 0;
        m_pend  = 0;
        m_timer = 0;
    endtask

    task automatic model_update();
        bit cap;
        bit ne;
        bit st;
        if (Reset) begin
            model_reset();
            return;
        end
        cap   = ResultValid && !m_prv;
        ne    = Next && !m_pnx;
        m_prv = ResultValid;
        m_pnx = Next;
        st    = 0;
        m_new = 0;
        if (Clear) begin
            hist.delete();
            m_off = 0;
            st    = 1;
        end else if (cap) begin
            hist.push_front(int'(DataResult));
            if (hist.size() > DEPTH)
                void'(hist.pop_back());
            m_off = 0;
            st    = 1;
            m_new = 1;
        end else if (ne && hist.size() > 0) begin
            m_off = (m_off + 1) % hist.size();
            st    = 1;
        end
        if (st) begin
            m_pend  = m_disp();
            m_timer = 8;
            m_ok    = 0;
        end else if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) begin
                m_bcd = to_bcd(m_pend);
                m_ok  = 1;
            end
        end
    endtask

    always @(negedge Clock) begin
        chk("disp", 32'(DispValue), 32'(m_disp()));
        chk("index", 32'(DispIndex), 32'(m_off));
        chk("count", 32'(Count), 32'(hist.size()));
        chk("bcd", 32'(Bcd), 32'(m_bcd));
        chk("bcdvalid", 32'(BcdValid), 32'(m_ok));
        chk("newresult", 32'(NewResult), 32'(m_new));
    end

    task automatic tick();
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic cap_wait(input logic [7:0] v, input int n);
        DataResult  = v;
        ResultValid = 1'b1;
        tick();
        ResultValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic press();
        Next = 1'b1;
        tick();
        Next = 1'b0;
        tick();
    endtask

    int ev[4] = '{4, 3, 2, 5};
    int ei[4] = '{1, 2, 3, 0};

    initial begin
        model_reset();
        #1 Reset = 1'b1;
        repeat (2) tick();
        chk("rst_disp", 32'(DispValue), 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_bcd", 32'(Bcd), 0);
        chk("rst_bv", 32'(BcdValid), 1);
        Reset = 1'b0;
        tick();

        DataResult  = 8'd27;
        ResultValid = 1'b1;
        tick();
        chk("c27_count", 32'(Count), 1);
        chk("c27_disp", 32'(DispValue), 27);
        chk("c27_new", 32'(NewResult), 1);
        chk("c27_bv0", 32'(BcdValid), 0);
        ResultValid = 1'b0;
        repeat (7) tick();
        chk("c27_bv_k7", 32'(BcdValid), 0);
        tick();
        chk("c27_bv_k8", 32'(BcdValid), 1);
        chk("c27_bcd", 32'(Bcd), 32'h027);
        repeat (4) tick();

        cap_wait(8'd244, 12);
        chk("bcd244", 32'(Bcd), 32'h244);
        cap_wait(8'd255, 12);
        chk("bcd255", 32'(Bcd), 32'h255);
        cap_wait(8'd0, 12);
        chk("bcd000", 32'(Bcd), 32'h000);
        chk("bv000", 32'(BcdValid), 1);

        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (10) tick();
        for (int v = 1; v <= 5; v++) cap_wait(8'(v), 12);
        chk("full_count", 32'(Count), 4);
        chk("full_disp", 32'(DispValue), 5);
        for (int i = 0; i < 4; i++) begin
            press();
            chk("browse_disp", 32'(DispValue), 32'(ev[i]));
            chk("browse_idx", 32'(DispIndex), 32'(ei[i]));
            repeat (9) tick();
        end

        DataResult  = 8'd9;
        ResultValid = 1'b1;
        tick();
        chk("hold_new1", 32'(NewResult), 1);
        tick();
        chk("hold_new2", 32'(NewResult), 0);
        tick();
        chk("hold_new3", 32'(NewResult), 0);
        ResultValid = 1'b0;
        tick();
        chk("hold_count", 32'(Count), 4);
        chk("hold_disp", 32'(DispValue), 9);
        repeat (10) tick();

        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (10) tick();
        Next = 1'b1;
        tick();
        chk("empty_disp", 32'(DispValue), 0);
        chk("empty_idx", 32'(DispIndex), 0);
        chk("empty_bv", 32'(BcdValid), 1);
        Next = 1'b0;
        tick();

        Clear       = 1'b1;
        ResultValid = 1'b1;
        DataResult  = 8'd77;
        tick();
        chk("clrcap_count", 32'(Count), 0);
        chk("clrcap_disp", 32'(DispValue), 0);
        chk("clrcap_new", 32'(NewResult), 0);
        Clear = 1'b0;
        tick();
        ResultValid = 1'b0;
        tick();
        chk("clrcap_count2", 32'(Count), 0);
        repeat (10) tick();

        cap_wait(8'd10, 12);
        cap_wait(8'd20, 12);
        press();
        chk("pre_disp", 32'(DispValue), 10);
        chk("pre_idx", 32'(DispIndex), 1);
        repeat (10) tick();
        DataResult  = 8'd30;
        ResultValid = 1'b1;
        Next        = 1'b1;
        tick();
        chk("capnext_disp", 32'(DispValue), 30);
        chk("capnext_idx", 32'(DispIndex), 0);
        ResultValid = 1'b0;
        Next        = 1'b0;
        repeat (12) tick();

        Next = 1'b1;
        tick();
        chk("abort_disp1", 32'(DispValue), 20);
        Next = 1'b0;
        repeat (2) tick();
        Next = 1'b1;
        tick();
        chk("abort_disp2", 32'(DispValue), 10);
        chk("abort_bv", 32'(BcdValid), 0);
        Next = 1'b0;
        repeat (7) tick();
        chk("abort_bv_k7", 32'(BcdValid), 0);
        tick();
        chk("abort_bv_k8", 32'(BcdValid), 1);
        chk("abort_bcd", 32'(Bcd), 32'h010);

        press();
        chk("wrap3_disp", 32'(DispValue), 30);
        tick();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("arst_disp", 32'(DispValue), 0);
        chk("arst_idx", 32'(DispIndex), 0);
        chk("arst_count", 32'(Count), 0);
        chk("arst_bcd", 32'(Bcd), 0);
        chk("arst_bv", 32'(BcdValid), 1);
        chk("arst_new", 32'(NewResult), 0);
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        cap_wait(8'd123, 12);
        chk("post_bcd", 32'(Bcd), 32'h123);
        chk("post_count", 32'(Count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_log.md
# result_log

Downstream capture and display stage for the polynomial evaluator. It records each 8-bit result the evaluator flags with its one-cycle `ResultValid`, and keeps the most recent `DEPTH` results in a circular history. It lets the user browse older entries with a key, and converts the displayed value to 3-digit BCD with a sequential double-dabble unit. Its outputs drive the HEX decoders and LEDs in the top level.

## Interface
- `DEPTH`, 4: history entries; power of two, 2..16.
- `Clock`  in  1: single clock; all state on its rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state.
- `DataResult`  in  8: evaluator result.
- `ResultValid`  in  1: evaluator result-valid strobe; may be held high for more than one cycle.
- `Next`  in  1: browse key (level, already synchronised); each rising edge steps to the next-older entry.
- `Clear`  in  1: synchronous flush of history; level-sensitive.
- `DispValue`  out  8: currently displayed entry.
- `DispIndex`  out  log2(DEPTH): age of the displayed entry; 0 = newest.
- `Count`  out  log2(DEPTH)+1: number of valid entries.
- `Bcd`  out  12: BCD of `DispValue`, hundreds in [11:8].
- `BcdValid`  out  1: `Bcd` matches `DispValue`.
- `NewResult`  out  1: one-cycle pulse on each capture.

## Operation
- **Reset values.** All outputs are 0 except `BcdValid`=1. `wr_ptr`=0, offset=0, buffer contents are don't-care.
- **Capture.**
  - A capture is a rising edge of `ResultValid` (registered previous value).
  - `DataResult` is written to `buf[wr_ptr]` and `wr_ptr` increments mod `DEPTH`.
  - `Count` increments, saturating at `DEPTH`. When full, the oldest entry is overwritten.
  - Offset resets to 0 and `NewResult` pulses.
- **Browse.**
  - A rising edge of `Next` with `Count`>0 sets offset to offset+1.
  - It wraps to 0 when offset = `Count`-1.
  - With `Count`=0 the edge is ignored.
- **Display.**
  - `DispValue` = `buf[(wr_ptr-1-offset) mod DEPTH]` when `Count`>0, else 0.
  - `DispIndex` = offset.
  - Both are registered.
- **Clear.** Sets `Count`=0, offset=0, `wr_ptr`=0 and `DispValue`=0.
- **Simultaneous events.** Priority is Clear > capture > browse.
  - A capture coincident with Clear is dropped.
  - A browse coincident with a capture is dropped.
- **BCD converter.** States IDLE and SHIFT, with a 3-bit bit counter.
  - Any change of `DispValue` source (capture, effective browse, Clear) starts a conversion on the same edge. The new display value is loaded into the shift register, the state goes to SHIFT, and `BcdValid` drops to 0.
  - Each cycle in SHIFT: add 3 to every BCD nibble ≥5, then shift left one bit.
  - After the 8th shift: `Bcd` is updated, `BcdValid`=1, state returns to IDLE.
  - A new start during SHIFT aborts the current conversion and restarts with the new value.
  - `Bcd` holds its previous value until a conversion completes.
- **Arithmetic.** Unsigned 8-bit, so the BCD range is 000–255. Pointer arithmetic is mod `DEPTH`.

## Timing
- **Capture latency.** With the `ResultValid` rising edge sampled at edge k, `DispValue`, `Count` and `NewResult` update at edge k.
- **BCD latency.**
  - `BcdValid` falls at edge k and `Bcd`/`BcdValid`=1 appear at edge k+8.
  - Maximum event rate sustaining valid BCD: one per 9 cycles.
- **Browse latency.** A `Next` rising edge seen at edge k updates `DispValue` at edge k; BCD is ready at k+8.
- **Reset.** Asynchronous assertion mid-conversion forces IDLE, `Bcd`=0 and `BcdValid`=1 immediately. Release is synchronous to `Clock`.
- **Back-to-back results.** The evaluator produces at most one result per 13 cycles, so the converter never needs to abort for captures alone.

## Structure
- **Shared package `result_log_pkg`:**
  - converter state enum {IDLE, SHIFT};
  - `BCD_W`=12;
  - `DATA_W`=8;
  - default `DEPTH`.
- **Sub-module `bin2bcd_seq`.** Contains the double-dabble FSM.
  - Ports: `Clock`, `Reset`, `Start`, `Bin[7:0]`, `Bcd[11:0]`, `Done`.
  - Restartable at any cycle.
- **Top `result_log`.** Holds the buffer, pointers, edge detectors and priority logic.

## Test plan
- Reset, then one capture of 27 (A=1, B=2, C=3, x=4) -> `Count`=1, `DispValue`=27, `NewResult` pulses once, `Bcd`=0x027 with `BcdValid` exactly 8 cycles later.
- Capture 244 (A=5, B=0, C=0, x=10, 8-bit wrap) -> `Bcd`=0x244. Capture 255 and 0 -> `Bcd`=0x255 and 0x000.
- Captures 1,2,3,4,5 with `DEPTH`=4 -> `Count`=4. Four `Next` edges show 5,4,3,2 then wrap to 5, with `DispIndex` 0,1,2,3,0.
- `ResultValid` held high 3 cycles -> exactly one capture. `Next` with `Count`=0 -> no change.
- Same-cycle events:
  - Clear and capture in the same cycle -> `Count`=0, `DispValue`=0, no `NewResult`.
  - Capture and `Next` in the same cycle -> offset 0.
- `Next` edge 3 cycles into a conversion -> abort and restart. `BcdValid` comes 8 cycles after the second start with the new value.
- Async `Reset` mid-conversion -> all outputs zero, `BcdValid`=1.
